seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 Parameter SIGNED, default 0; 0 = unsigned operands, 1 = two's-complement operands.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a new division; sampled at the rising edge.
REQ-006 dividend  input  WIDTH  numerator; sampled only on an accepted start.
REQ-007 divisor  input  WIDTH  denominator; sampled only on an accepted start.
REQ-008 quotient  output  WIDTH  registered result; holds until the next result.
REQ-009 remainder  output  WIDTH  registered result; holds until the next result.
REQ-010 busy  output  1  high while an iteration is in progress (state CALC).
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 div_by_zero  output  1  high with done when the divisor was 0; held until the next accepted start.

Function
REQ-013 Use a three-state FSM: IDLE, CALC and DONE.
REQ-014 A start SHALL be accepted only in IDLE or DONE; start while in CALC SHALL be ignored, with no effect on state or operands.
REQ-015 On acceptance with divisor != 0, the block SHALL latch the operands, clear div_by_zero, enter CALC and clear the step counter.
REQ-016 CALC SHALL perform one radix-2 restoring shift/subtract step per cycle, for exactly WIDTH steps.
REQ-017 After step WIDTH, the block SHALL register quotient and remainder, enter DONE and assert done.
REQ-018 Latency: done SHALL be high in the cycle that begins WIDTH rising edges after the accepting edge.
REQ-019 DONE SHALL last one cycle, then return to IDLE; if start is high in DONE, it is accepted and the next state follows REQ-015/REQ-020.
REQ-020 On acceptance with divisor == 0: go directly to DONE, quotient = 0, remainder = 0, div_by_zero = 1; done is high in the cycle after the accepting edge.
REQ-021 Unsigned mode results: quotient = floor(dividend/divisor), remainder = dividend mod divisor.
REQ-022 Signed mode: divide the magnitudes, then truncate toward zero; quotient negative iff the operand signs differ; remainder takes the dividend's sign.
REQ-023 Signed overflow (most-negative / -1): quotient = most-negative value (wraps), remainder = 0, div_by_zero = 0.
REQ-024 quotient and remainder SHALL update only on entry to DONE; they hold their values in IDLE and CALC.
REQ-025 busy SHALL be 1 exactly in CALC; done SHALL be 1 exactly in DONE.
REQ-026 Internal working registers are WIDTH-bit for quotient/dividend and WIDTH+1-bit for the partial remainder; there is no truncation loss.

Reset
REQ-027 While rst_n is low: state = IDLE, step counter = 0, quotient = 0, remainder = 0, busy = 0, done = 0, div_by_zero = 0.
REQ-028 Reset asserted mid-CALC SHALL abort the operation immediately with no done pulse; after release, the block waits in IDLE for a new start.
REQ-029 A start coincident with the first rising edge after rst_n release SHALL be accepted normally.

Verification
REQ-030 WIDTH=8, SIGNED=0, dividend=200, divisor=7, start pulse -> busy for 8 cycles; done in cycle 8 after acceptance with quotient=28, remainder=4, div_by_zero=0.
REQ-031 WIDTH=8, SIGNED=0, dividend=15, divisor=0 -> done in the next cycle with quotient=0, remainder=0, div_by_zero=1; busy never asserted.
REQ-032 WIDTH=8, SIGNED=1, dividend=-7 (0xF9), divisor=2 -> quotient=-3 (0xFD), remainder=-1 (0xFF); and -128 / -1 -> quotient=0x80, remainder=0.
REQ-033 Start pulsed again during CALC with different operands -> ignored; the first result is returned unchanged at the original latency.
REQ-034 Start held high continuously, operands 100/10 then 9/3 -> back-to-back results 10 r0 then 3 r0, each accepted in its DONE cycle, with no IDLE gap.
REQ-035 rst_n pulsed low at CALC step 4 -> all outputs go to 0 asynchronously and no done pulse occurs; a following start with 50/5 -> quotient=10, remainder=0.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider: one quotient bit per clock, with
// optional two's-complement operands handled by sign/magnitude conversion.
module seq_divider #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   r_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rmd;
  logic             r_dbz;

  logic             w_accept;
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_qbit;
  logic [WIDTH:0]   w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_q_final;
  logic [WIDTH-1:0] w_r_final;
  logic             w_last;

  assign w_accept  = start && (r_state != S_CALC);
  assign w_dvd_neg = (SIGNED != 0) && dividend[WIDTH-1];
  assign w_dvs_neg = (SIGNED != 0) && divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag = w_dvs_neg ? -divisor  : divisor;

  // Dividend register doubles as the quotient shift register: its MSB feeds
  // the partial remainder while the new quotient bit enters at the LSB.
  assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff     = w_shift - {2'b00, r_dvs};
  assign w_qbit     = ~w_diff[WIDTH+1];
  assign w_rem_next = w_qbit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
  assign w_quo_next = {r_dvd[WIDTH-2:0], w_qbit};
  assign w_q_final  = r_neg_q ? -w_quo_next : w_quo_next;
  assign w_r_final  = r_neg_r ? -w_rem_next[WIDTH-1:0] : w_rem_next[WIDTH-1:0];
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_quo   <= '0;
      r_rmd   <= '0;
      r_dbz   <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      if (divisor == '0) begin
        r_state <= S_DONE;
        r_quo   <= '0;
        r_rmd   <= '0;
        r_dbz   <= 1'b1;
      end else begin
        r_state <= S_CALC;
        r_dvd   <= w_dvd_mag;
        r_dvs   <= w_dvs_mag;
        r_rem   <= '0;
        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
        r_neg_r <= w_dvd_neg;
        r_dbz   <= 1'b0;
      end
    end else if (r_state == S_CALC) begin
      r_rem <= w_rem_next;
      r_dvd <= w_quo_next;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_state <= S_DONE;
        r_quo   <= w_q_final;
        r_rmd   <= w_r_final;
      end
    end else if (r_state == S_DONE) begin
      r_state <= S_IDLE;
    end
  end

  assign quotient    = r_quo;
  assign remainder   = r_rmd;
  assign div_by_zero = r_dbz;
  assign busy        = (r_state == S_CALC);
  assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: an unsigned and a signed instance run the same
// operand stream and are compared against an integer-arithmetic model.
module tb_seq_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] u_q, u_r, s_q, s_r;
  logic       u_busy, u_done, u_dbz, s_busy, s_done, s_dbz;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } res_t;

  seq_divider #(.WIDTH(8), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(u_q), .remainder(u_r), .busy(u_busy), .done(u_done), .div_by_zero(u_dbz)
  );

  seq_divider #(.WIDTH(8), .SIGNED(1)) s_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(s_q), .remainder(s_r), .busy(s_busy), .done(s_done), .div_by_zero(s_dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input bit sgn);
    res_t o;
    int   sa, sb;
    o = '0;
    if (b == 8'd0) begin
      o.dbz = 1'b1;
    end else if (!sgn) begin
      o.q = 8'(int'(a) / int'(b));
      o.r = 8'(int'(a) % int'(b));
    end else begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -128 && sb == -1) begin
        o.q = 8'h80;
        o.r = 8'h00;
      end else begin
        o.q = 8'(sa / sb);
        o.r = 8'(sa % sb);
      end
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [7:0] a, input logic [7:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Observation only: edges from now until done, and busy cycles seen.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (u_done !== 1'b1 && lat < 40) begin
      if (u_busy === 1'b1) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    int lat, bc;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (u_q !== 8'd0)    begin errors++; $display("FAIL reset_u_q got=%h exp=00", u_q); end
    checks++; if (u_r !== 8'd0)    begin errors++; $display("FAIL reset_u_r got=%h exp=00", u_r); end
    checks++; if (u_busy !== 1'b0) begin errors++; $display("FAIL reset_u_busy got=%b exp=0", u_busy); end
    checks++; if (u_done !== 1'b0) begin errors++; $display("FAIL reset_u_done got=%b exp=0", u_done); end
    checks++; if (u_dbz !== 1'b0)  begin errors++; $display("FAIL reset_u_dbz got=%b exp=0", u_dbz); end
    checks++; if ({s_q, s_r, s_busy, s_done, s_dbz} !== 19'd0)
      begin errors++; $display("FAIL reset_s_outs got=%h exp=0", {s_q, s_r, s_busy, s_done, s_dbz}); end
    rst_n = 1'b1;
    // start is high at the very first edge after release
    drive_op(8'd200, 8'd7);
    wait_done(lat, bc);
    checks++; if (lat != 8) begin errors++; $display("FAIL first_op_latency got=%0d exp=8", lat); end
    checks++; if (bc != 8)  begin errors++; $display("FAIL first_op_busy_cycles got=%0d exp=8", bc); end
    checks++; if (u_q !== 8'd28) begin errors++; $display("FAIL first_op_q got=%0d exp=28", u_q); end
    checks++; if (u_r !== 8'd4)  begin errors++; $display("FAIL first_op_r got=%0d exp=4", u_r); end
    checks++; if (u_dbz !== 1'b0) begin errors++; $display("FAIL first_op_dbz got=%b exp=0", u_dbz); end
    tick();
  endtask

  task automatic test_examples();
    int lat, bc;
    drive_op(8'd15, 8'd0);
    wait_done(lat, bc);
    checks++; if (lat != 0) begin errors++; $display("FAIL dbz_latency got=%0d exp=0", lat); end
    checks++; if (bc != 0)  begin errors++; $display("FAIL dbz_busy got=%0d exp=0", bc); end
    checks++; if ({u_q, u_r, u_dbz} !== {8'd0, 8'd0, 1'b1})
      begin errors++; $display("FAIL dbz_result got=%h/%h/%b exp=00/00/1", u_q, u_r, u_dbz); end
    tick();
    checks++; if (u_done !== 1'b0 || u_dbz !== 1'b1)
      begin errors++; $display("FAIL dbz_hold got done=%b dbz=%b exp done=0 dbz=1", u_done, u_dbz); end
    drive_op(8'hF9, 8'd2);
    wait_done(lat, bc);
    checks++; if ({s_q, s_r} !== {8'hFD, 8'hFF})
      begin errors++; $display("FAIL signed_m7_div2 got=%h/%h exp=fd/ff", s_q, s_r); end
    tick();
    drive_op(8'h80, 8'hFF);
    wait_done(lat, bc);
    checks++; if ({s_q, s_r, s_dbz} !== {8'h80, 8'h00, 1'b0})
      begin errors++; $display("FAIL signed_overflow got=%h/%h/%b exp=80/00/0", s_q, s_r, s_dbz); end
    tick();
  endtask

  task automatic test_ops();
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] da[8] = '{8'd0, 8'd255, 8'd3, 8'd255, 8'd128, 8'd127, 8'd1, 8'd0};
    logic [7:0] db[8] = '{8'd5, 8'd1, 8'd200, 8'd255, 8'd255, 8'd1, 8'd0, 8'd0};
    res_t eu, es;
    int lat, bc, elat;
    for (int i = 0; i < 8; i++) begin qa.push_back(da[i]); qb.push_back(db[i]); end
    for (int i = 0; i < 40; i++) begin
      qa.push_back(8'($urandom));
      qb.push_back(($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom));
    end
    for (int i = 0; i < qa.size(); i++) begin
      eu = model(qa[i], qb[i], 1'b0);
      es = model(qa[i], qb[i], 1'b1);
      elat = (qb[i] == 8'd0) ? 0 : 8;
      drive_op(qa[i], qb[i]);
      wait_done(lat, bc);
      checks++; if (lat != elat) begin errors++; $display("FAIL op_latency a=%0d b=%0d got=%0d exp=%0d", qa[i], qb[i], lat, elat); end
      checks++; if (bc != elat)  begin errors++; $display("FAIL op_busy a=%0d b=%0d got=%0d exp=%0d", qa[i], qb[i], bc, elat); end
      checks++; if ({u_q, u_r, u_dbz} !== eu)
        begin errors++; $display("FAIL op_unsigned a=%0d b=%0d got=%h/%h/%b exp=%h/%h/%b", qa[i], qb[i], u_q, u_r, u_dbz, eu.q, eu.r, eu.dbz); end
      checks++; if ({s_done, s_q, s_r, s_dbz} !== {1'b1, es})
        begin errors++; $display("FAIL op_signed a=%h b=%h got=%b %h/%h/%b exp=1 %h/%h/%b", qa[i], qb[i], s_done, s_q, s_r, s_dbz, es.q, es.r, es.dbz); end
      tick();
      tick();
      checks++; if (u_done !== 1'b0 || {u_q, u_r, u_dbz} !== eu)
        begin errors++; $display("FAIL op_hold a=%0d b=%0d got done=%b %h/%h exp done=0 %h/%h", qa[i], qb[i], u_done, u_q, u_r, eu.q, eu.r); end
    end
  endtask

  task automatic test_ignore_in_calc();
    res_t es;
    int lat, bc;
    es = model(8'd200, 8'd7, 1'b1);
    drive_op(8'd200, 8'd7);
    tick();
    tick();
    start = 1'b1; dividend = 8'd50; divisor = 8'd3;
    tick();
    start = 1'b0;
    wait_done(lat, bc);
    checks++; if (lat + 3 != 8) begin errors++; $display("FAIL ignore_latency got=%0d exp=8", lat + 3); end
    checks++; if ({u_q, u_r} !== {8'd28, 8'd4})
      begin errors++; $display("FAIL ignore_result got=%0d r%0d exp=28 r4", u_q, u_r); end
    checks++; if ({s_q, s_r} !== {es.q, es.r})
      begin errors++; $display("FAIL ignore_signed got=%h/%h exp=%h/%h", s_q, s_r, es.q, es.r); end
    tick();
    checks++; if (u_busy !== 1'b0 || u_done !== 1'b0)
      begin errors++; $display("FAIL ignore_idle got busy=%b done=%b exp 0/0", u_busy, u_done); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    start = 1'b1; dividend = 8'd100; divisor = 8'd10;
    tick();
    dividend = 8'd9; divisor = 8'd3;
    wait_done(lat, bc);
    checks++; if (lat != 8 || {u_q, u_r} !== {8'd10, 8'd0})
      begin errors++; $display("FAIL b2b_first got lat=%0d %0d r%0d exp lat=8 10 r0", lat, u_q, u_r); end
    tick();
    checks++; if (u_busy !== 1'b1 || u_done !== 1'b0)
      begin errors++; $display("FAIL b2b_no_gap got busy=%b done=%b exp 1/0", u_busy, u_done); end
    start = 1'b0;
    wait_done(lat, bc);
    checks++; if (lat != 8 || {u_q, u_r} !== {8'd3, 8'd0})
      begin errors++; $display("FAIL b2b_second got lat=%0d %0d r%0d exp lat=8 3 r0", lat, u_q, u_r); end
    checks++; if ({s_q, s_r} !== {8'd3, 8'd0})
      begin errors++; $display("FAIL b2b_signed got=%h/%h exp=03/00", s_q, s_r); end
    tick();
    checks++; if (u_done !== 1'b0)
      begin errors++; $display("FAIL b2b_end_done got=%b exp=0", u_done); end
  endtask

  task automatic test_reset_mid_calc();
    int lat, bc, seen;
    drive_op(8'd77, 8'd5);
    wait_done(lat, bc);
    tick();
    drive_op(8'd100, 8'd7);
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({u_q, u_r, u_busy, u_done, u_dbz} !== 19'd0)
      begin errors++; $display("FAIL async_reset_u got=%h exp=0", {u_q, u_r, u_busy, u_done, u_dbz}); end
    checks++; if ({s_q, s_r, s_busy, s_done, s_dbz} !== 19'd0)
      begin errors++; $display("FAIL async_reset_s got=%h exp=0", {s_q, s_r, s_busy, s_done, s_dbz}); end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (u_done === 1'b1 || u_busy === 1'b1) seen++;
      tick();
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL reset_abort_activity got=%0d exp=0", seen); end
    drive_op(8'd50, 8'd5);
    wait_done(lat, bc);
    checks++; if (lat != 8 || {u_q, u_r} !== {8'd10, 8'd0})
      begin errors++; $display("FAIL after_reset_op got lat=%0d %0d r%0d exp lat=8 10 r0", lat, u_q, u_r); end
    tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    test_reset();
    test_examples();
    test_ops();
    test_ignore_in_calc();
    test_back_to_back();
    test_reset_mid_calc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
